// File: rtl/uart_pkg.sv
// Shared types for the UART receive path: receiver state encoding and frame constants.
package uart_pkg;

  localparam int DATA_BITS = 8;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } uart_rx_state_t;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for asynchronous single-bit inputs (rx pin, push buttons).
module sync_2ff #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk) begin
    if (reset) begin
      meta <= RESET_VAL;
      q    <= RESET_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/uart_rx_byte.sv
// UART byte receiver (8N1, or 8E1 when UART_RX_PARITY_EN is defined), centre-sampled.
// Strobes: data_valid, frame_err and parity_err are one-cycle, mutually exclusive pulses with no ready/back-pressure; data_out is valid in the data_valid cycle and holds until the next good frame.
module uart_rx_byte
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 868
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx,
  output logic [7:0] data_out,
  output logic       data_valid,
  output logic       frame_err,
  output logic       parity_err,
  output logic       busy
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] BIT_END  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] HALF_END = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [2:0]       LAST_BIT = 3'(DATA_BITS - 1);

  uart_rx_state_t           state;
  logic [CNT_W-1:0]         cnt;
  logic [2:0]               bit_idx;
  logic [DATA_BITS-1:0]     shreg;
  logic                     rx_s;
  logic                     par_bad;

  sync_2ff #(.RESET_VAL(1'b1)) u_sync (
    .clk   (clk),
    .reset (reset),
    .d     (rx),
    .q     (rx_s)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      cnt        <= '0;
      bit_idx    <= '0;
      shreg      <= '0;
      par_bad    <= 1'b0;
      data_out   <= 8'h00;
      data_valid <= 1'b0;
      frame_err  <= 1'b0;
`ifdef UART_RX_PARITY_EN
      parity_err <= 1'b0;
`endif
      busy       <= 1'b0;
    end else begin
      data_valid <= 1'b0;
      frame_err  <= 1'b0;
`ifdef UART_RX_PARITY_EN
      parity_err <= 1'b0;
`endif
      busy       <= (state != IDLE);
      case (state)
        IDLE: begin
          if (!rx_s) begin
            cnt   <= '0;
            state <= START;
          end
        end
        START: begin
          // A start bit that is high again by its centre is a glitch, not a frame.
          if (cnt == HALF_END) begin
            cnt <= '0;
            if (!rx_s) begin
              bit_idx <= '0;
              par_bad <= 1'b0;
              state   <= DATA;
            end else begin
              state <= IDLE;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DATA: begin
          if (cnt == BIT_END) begin
            cnt            <= '0;
            shreg[bit_idx] <= rx_s;
            if (bit_idx == LAST_BIT) begin
`ifdef UART_RX_PARITY_EN
              state <= PARITY;
`else
              state <= STOP;
`endif
            end else begin
              bit_idx <= bit_idx + 1'b1;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
`ifdef UART_RX_PARITY_EN
        PARITY: begin
          if (cnt == BIT_END) begin
            cnt     <= '0;
            par_bad <= (rx_s != ^shreg);
            state   <= STOP;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
`endif
        STOP: begin
          // Leaving at the stop-bit centre leaves half a bit to catch the next start edge.
          if (cnt == BIT_END) begin
            cnt   <= '0;
            state <= IDLE;
            if (!rx_s) begin
              frame_err <= 1'b1;
            end else if (par_bad) begin
`ifdef UART_RX_PARITY_EN
              parity_err <= 1'b1;
`endif
            end else begin
              data_out   <= shreg;
              data_valid <= 1'b1;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifndef UART_RX_PARITY_EN
  assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_byte.sv
// Scoreboard bench for uart_rx_byte at 16 clocks per bit; define UART_RX_PARITY_EN to add the parity cases.
module tb_uart_rx_byte;

  localparam int CLKS = 16;
`ifdef UART_RX_PARITY_EN
  localparam int FRAME_BITS = 11;
`else
  localparam int FRAME_BITS = 10;
`endif
  // Pin start edge to data_valid: up to the stop-bit centre plus 2 sync flops and the output register.
  localparam int EXP_LAT = CLKS * FRAME_BITS - CLKS / 2 + 3;

  localparam logic [1:0] K_VALID = 2'd0;
  localparam logic [1:0] K_FERR  = 2'd1;
  localparam logic [1:0] K_PERR  = 2'd2;

  logic       clk;
  logic       reset;
  logic       rx;
  logic [7:0] data_out;
  logic       data_valid;
  logic       frame_err;
  logic       parity_err;
  logic       busy;

  int total;
  int bad;
  int cyc;
  int start_cyc;
  int last_valid_cyc;
  logic [9:0] exp_q[$];

  uart_rx_byte #(.CLKS_PER_BIT(CLKS)) dut (
    .clk        (clk),
    .reset      (reset),
    .rx         (rx),
    .data_out   (data_out),
    .data_valid (data_valid),
    .frame_err  (frame_err),
    .parity_err (parity_err),
    .busy       (busy)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Driver tasks (called at a negedge, return at a negedge)
  task automatic idle(input int n);
    rx = 1'b1;
    repeat (n) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] b, input logic par, input logic stop);
    start_cyc = cyc;
    rx = 1'b0;
    repeat (CLKS) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (CLKS) @(negedge clk);
    end
`ifdef UART_RX_PARITY_EN
    rx = par;
    repeat (CLKS) @(negedge clk);
`else
    if (par) begin end
`endif
    rx = stop;
    repeat (CLKS) @(negedge clk);
    rx = 1'b1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_idle_outputs(input string name);
    check({name, "_data_out"}, 32'(data_out), 32'h00);
    check({name, "_data_valid"}, 32'(data_valid), 32'h0);
    check({name, "_frame_err"}, 32'(frame_err), 32'h0);
    check({name, "_parity_err"}, 32'(parity_err), 32'h0);
    check({name, "_busy"}, 32'(busy), 32'h0);
  endtask

  // Scoreboard monitor: every output pulse pops one expected event
  always @(negedge clk) begin
    logic [9:0] act;
    logic [9:0] e;
    if (!reset && (data_valid || frame_err || parity_err)) begin
      total++;
      if (data_valid) act = {K_VALID, data_out};
      else if (frame_err) act = {K_FERR, 8'h00};
      else act = {K_PERR, 8'h00};
      if (32'(data_valid) + 32'(frame_err) + 32'(parity_err) > 1) begin
        bad++;
        $display("FAIL pulse_overlap: got valid=%b ferr=%b perr=%b expected one pulse",
                 data_valid, frame_err, parity_err);
      end else if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL unexpected_pulse: got kind=%0d data=%02h expected none", act[9:8], act[7:0]);
      end else begin
        e = exp_q.pop_front();
        if (act !== e) begin
          bad++;
          $display("FAIL pulse_event: got kind=%0d data=%02h expected kind=%0d data=%02h",
                   act[9:8], act[7:0], e[9:8], e[7:0]);
        end
      end
      if (data_valid) last_valid_cyc = cyc;
    end
  end

  initial begin
    total = 0;
    bad = 0;
    last_valid_cyc = -1;
    start_cyc = 0;
    rx = 1'b1;
    reset = 1'b1;
    repeat (4) @(negedge clk);
    check_idle_outputs("reset");
    reset = 1'b0;
    idle(20);

    // 1: single byte "a", latency from start edge
    exp_q.push_back({K_VALID, 8'h61});
    send_frame(8'h61, 1'b1, 1'b1);
    idle(CLKS * 2);
    check("a_latency_ok", 32'((last_valid_cyc - start_cyc >= EXP_LAT - 1) &&
                              (last_valid_cyc - start_cyc <= EXP_LAT + 1)), 32'h1);
    check("a_data_out", 32'(data_out), 32'h61);

    // 2: "andre" back-to-back with one stop bit
    exp_q.push_back({K_VALID, 8'h61});
    exp_q.push_back({K_VALID, 8'h6E});
    exp_q.push_back({K_VALID, 8'h64});
    exp_q.push_back({K_VALID, 8'h72});
    exp_q.push_back({K_VALID, 8'h65});
    send_frame(8'h61, 1'b1, 1'b1);
    send_frame(8'h6E, 1'b1, 1'b1);
    send_frame(8'h64, 1'b1, 1'b1);
    send_frame(8'h72, 1'b0, 1'b1);
    send_frame(8'h65, 1'b0, 1'b1);
    idle(CLKS * 2);
    check("andre_drained", 32'(exp_q.size()), 32'h0);

    // 3: 4-cycle glitch, busy must drop within 12 cycles
    rx = 1'b0;
    repeat (4) @(negedge clk);
    rx = 1'b1;
    repeat (8) @(negedge clk);
    check("glitch_busy_clear", 32'(busy), 32'h0);
    idle(CLKS * 2);

    // 4: 8'hA5 with stop bit low
    exp_q.push_back({K_FERR, 8'h00});
    send_frame(8'hA5, 1'b0, 1'b0);
    idle(CLKS * 3);
    check("ferr_data_out_held", 32'(data_out), 32'h65);
    check("ferr_busy_clear", 32'(busy), 32'h0);

    // 5: reset in the middle of bit 3, then 8'h3C
    rx = 1'b0;
    repeat (CLKS) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      rx = ((8'h96 >> i) & 8'h01) != 8'h00;
      repeat (CLKS) @(negedge clk);
    end
    rx = 1'b0;
    repeat (CLKS / 2) @(negedge clk);
    reset = 1'b1;
    rx = 1'b1;
    repeat (3) @(negedge clk);
    check_idle_outputs("midreset");
    reset = 1'b0;
    idle(CLKS * 12);
    check("post_reset_data_out", 32'(data_out), 32'h00);
    exp_q.push_back({K_VALID, 8'h3C});
    send_frame(8'h3C, 1'b0, 1'b1);
    idle(CLKS * 2);
    check("3c_data_out", 32'(data_out), 32'h3C);

`ifdef UART_RX_PARITY_EN
    // 6: even parity on 8'h07
    exp_q.push_back({K_VALID, 8'h07});
    send_frame(8'h07, 1'b1, 1'b1);
    idle(CLKS * 2);
    check("par_ok_data_out", 32'(data_out), 32'h07);
    exp_q.push_back({K_PERR, 8'h00});
    send_frame(8'h07, 1'b0, 1'b1);
    idle(CLKS * 2);
    check("par_bad_data_out_held", 32'(data_out), 32'h07);
`endif

    idle(CLKS * 2);
    check("queue_drained", 32'(exp_q.size()), 32'h0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
